// File: rtl/stage2_magnitude.sv
// stage2_magnitude: computes magMN = clamp(floor(sqrt(M^2 + N^2))) for the
// arcsin-quotient divider and forwards L alongside it.
//
// Ports:
//   clock, resetn        - system clock, synchronous active-low reset
//   validIn, M, N, L     - single-cycle input sample (signed 16-bit)
//   inReady              - high only while idle; a sample is accepted then
//   Lout, magMN          - captured L and clamped magnitude (held until next result)
//   validOut             - one-cycle pulse, 19 cycles after the accepting edge
//   satFlag, zeroFlag    - raw root above MAG_MAX / raw root equal to zero
//   overrun              - sticky: validIn arrived while busy
//
// Pipeline: IDLE -> SQUARE -> SUM -> ROOT (16 cycles) -> DONE -> IDLE.
module stage2_magnitude #(
  parameter logic [15:0] MAG_MAX = 16'd32767,
  parameter logic [15:0] MAG_MIN = 16'd1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        validIn,
  input  logic [15:0] M,
  input  logic [15:0] N,
  input  logic [15:0] L,
  output logic        inReady,
  output logic [15:0] Lout,
  output logic [15:0] magMN,
  output logic        validOut,
  output logic        satFlag,
  output logic        zeroFlag,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, SQUARE, SUM, ROOT, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] m_q, m_d, n_q, n_d, l_q, l_d;
  logic [30:0] sqm_q, sqm_d, sqn_q, sqn_d;
  logic [31:0] x_q, x_d;
  logic [17:0] rem_q, rem_d;
  logic [15:0] root_q, root_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] lout_q, lout_d, mag_q, mag_d;
  logic        vout_q, vout_d, sat_q, sat_d, zero_q, zero_d, ovr_q, ovr_d;

  logic signed [31:0] prod_m, prod_n;
  logic [17:0]        rem_sh, trial;
  logic               unused_bits;

  // Squares of signed 16-bit values are at most 2^30, so bit 31 is always 0.
  assign prod_m = $signed(m_q) * $signed(m_q);
  assign prod_n = $signed(n_q) * $signed(n_q);

  // The partial remainder never exceeds 2*root, so before the last step it
  // fits in 16 bits; shifting in two radicand bits yields an 18-bit value.
  assign rem_sh = {rem_q[15:0], x_q[31:30]};
  assign trial  = {root_q, 2'b01};

  assign unused_bits = ^{rem_q[17:16], prod_m[31], prod_n[31]};

  assign inReady  = (state_q == IDLE);
  assign Lout     = lout_q;
  assign magMN    = mag_q;
  assign validOut = vout_q;
  assign satFlag  = sat_q;
  assign zeroFlag = zero_q;
  assign overrun  = ovr_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    l_d     = l_q;
    sqm_d   = sqm_q;
    sqn_d   = sqn_q;
    x_d     = x_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    lout_d  = lout_q;
    mag_d   = mag_q;
    sat_d   = sat_q;
    zero_d  = zero_q;
    vout_d  = 1'b0;
    // Busy-time samples are dropped but remembered.
    ovr_d   = ovr_q | (validIn & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (validIn) begin
          m_d     = M;
          n_d     = N;
          l_d     = L;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        sqm_d   = prod_m[30:0];
        sqn_d   = prod_n[30:0];
        state_d = SUM;
      end
      SUM: begin
        x_d     = {1'b0, sqm_q} + {1'b0, sqn_q};
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = 4'd15;
        state_d = ROOT;
      end
      ROOT: begin
        // Restoring square root: one result bit per cycle, MSB first.
        if (rem_sh >= trial) begin
          rem_d  = rem_sh - trial;
          root_d = {root_q[14:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          root_d = {root_q[14:0], 1'b0};
        end
        x_d = {x_q[29:0], 2'b00};
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE: begin
        if (root_q > MAG_MAX)      mag_d = MAG_MAX;
        else if (root_q < MAG_MIN) mag_d = MAG_MIN;
        else                       mag_d = root_q;
        sat_d   = (root_q > MAG_MAX);
        zero_d  = (root_q == 16'd0);
        lout_d  = l_q;
        vout_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      m_q     <= '0;
      n_q     <= '0;
      l_q     <= '0;
      sqm_q   <= '0;
      sqn_q   <= '0;
      x_q     <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      lout_q  <= '0;
      mag_q   <= '0;
      vout_q  <= 1'b0;
      sat_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      l_q     <= l_d;
      sqm_q   <= sqm_d;
      sqn_q   <= sqn_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      lout_q  <= lout_d;
      mag_q   <= mag_d;
      vout_q  <= vout_d;
      sat_q   <= sat_d;
      zero_q  <= zero_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: doc/stage2_magnitude.md
Name: stage2_magnitude

Overview:
- Upstream neighbour of the arcsin-quotient divider stage.
- Computes the divisor magMN = floor(sqrt(M^2 + N^2)) using an iterative bit-serial square root.
- Forwards L aligned with magMN so the divider stage receives matched L/magMN with a single-cycle validOut pulse.
- Clamps magMN to a safe range so the downstream divider never sees zero and never sees an unrepresentable value.

Parameters:
MAG_MAX, 32767, upper saturation bound for magMN (signed 16-bit max).
MAG_MIN, 1, lower clamp for magMN, preventing divide-by-zero downstream.

Ports:
clock  input  1  system clock; all logic on posedge.
resetn  input  1  synchronous reset, active-low.
validIn  input  1  single-cycle pulse; M, N and L are valid in the same cycle.
M  input  16  signed plane coefficient.
N  input  16  signed plane coefficient.
L  input  16  signed plane coefficient, forwarded unchanged.
inReady  output  1  high when the block is idle and will accept validIn.
Lout  output reg  16  signed registered copy of the captured L.
magMN  output reg  16  signed clamped magnitude, always within [MAG_MIN, MAG_MAX].
validOut  output reg  1  one-cycle pulse; Lout and magMN are valid in that cycle.
satFlag  output reg  1  high with validOut when the raw root exceeded MAG_MAX.
zeroFlag  output reg  1  high with validOut when the raw root was 0 (M = N = 0).
overrun  output reg  1  sticky; set when validIn arrives while inReady = 0.

Behaviour:
- Reset: when resetn = 0 at a posedge:
  - state goes to IDLE;
  - Lout, magMN, validOut, satFlag, zeroFlag, overrun all go to 0;
  - internal registers are cleared;
  - a reset during any state aborts the computation and no validOut is produced.
- FSM states: IDLE, SQUARE, SUM, ROOT, DONE. inReady = 1 only in IDLE (combinational decode of state).
- IDLE:
  - validIn = 1 at edge k: capture M, N, L and go to SQUARE.
  - Otherwise stay in IDLE.
- SQUARE (edge k+1):
  - sqM = M*M, sqN = N*N; each is 31-bit unsigned, max 2^30.
  - Go to SUM.
- SUM (edge k+2):
  - X = sqM + sqN, 32-bit unsigned, max 2^31, no overflow.
  - Set rem = 0, root = 0, iteration counter = 15.
  - Go to ROOT.
- ROOT (edges k+3 .. k+18, 16 iterations, one result bit per cycle). Each iteration:
  - rem' = {rem, X[31:30]}; X <<= 2;
  - trial = {root, 2'b01};
  - if rem' >= trial: rem = rem' - trial, root = {root, 1};
  - else: rem = rem', root = {root, 0}.
  - rem is 18 bits wide; root is 16-bit unsigned.
  - When the counter reaches 0, go to DONE; otherwise decrement the counter.
- DONE (edge k+19): update all outputs together:
  - magMN = root > MAG_MAX ? MAG_MAX : (root < MAG_MIN ? MAG_MIN : root);
  - satFlag = (root > MAG_MAX);
  - zeroFlag = (root == 0);
  - Lout = captured L;
  - validOut = 1;
  - go to IDLE.
- Output timing:
  - Fixed latency: validOut rises at edge k+19, i.e. 19 cycles after the validIn sample edge.
  - validOut drops at the next edge.
  - magMN, Lout and the flags hold their values until the next DONE.
- Throughput: the earliest next accept is edge k+20, giving one sample per 20 cycles.
- Overrun handling:
  - validIn while not in IDLE is ignored; the in-flight computation is unaffected.
  - overrun is set to 1 and stays set until reset.
- Simultaneous events:
  - validIn on the same edge the FSM enters IDLE (edge k+19) is not accepted, because inReady was 0 in that cycle; overrun is set.
  - resetn = 0 has priority over validIn.
- Numerical results:
  - The result is an exact floor square root over the full input range.
  - Input M = N = -32768 gives X = 2^31, root = 46340, which saturates.

Test Plan:
- M = 3, N = 4, L = 2, one validIn pulse -> validOut exactly 19 cycles later; magMN = 5, Lout = 2; satFlag = 0, zeroFlag = 0; inReady low for 19 cycles.
- M = 255, N = -255, L = -100 -> magMN = 360 (floor of sqrt(130050)), Lout = -100. Also M = 181, N = 0 -> 181 (exact square).
- M = -32768, N = -32768 -> magMN = 32767, satFlag = 1. Also M = 32767, N = 0 -> magMN = 32767, satFlag = 0.
- M = 0, N = 0, L = 0 -> magMN = 1, zeroFlag = 1. Also M = -1, N = 0 -> magMN = 1, zeroFlag = 0.
- validIn at cycle 0, then pulses at cycles 5 and 19, then at cycle 20:
  - cycles 5 and 19 are ignored and set overrun = 1;
  - the first result is unchanged;
  - the cycle-20 sample completes at cycle 39.
- Assert resetn = 0 at cycle 10 of a computation -> no validOut; all outputs 0; inReady = 1 on the next cycle; a subsequent sample completes normally.
